conv_tap5_engine: RTL
=====================

// Module: conv_tap5_engine
// PURPOSE
//  Downstream consumer of the 5-bank convolution address counter. Steps that counter once per pixel and takes the
//  5 BRAM read words it addresses (bank k at base k*BANK_DEPTH), then computes a 5-tap weighted sum.
//  Rounds, shifts and saturates the result, then writes one output pixel per index to the result BRAM.
//  Runs one full frame (BANK_DEPTH indices) per start pulse, fully pipelined, one pixel per clock.
// PARAMETERS
//  DATA_W      8      pixel width (unsigned) for d1..d5 and out_data
//  COEF_W      8      coefficient width (signed two's complement)
//  ACC_W       20     accumulator width (signed); holds 5 products without overflow
//  SHIFT       4      right-shift applied to the sum (fixed-point scale of coefficients)
//  BANK_DEPTH  11520  indices per frame = words per bank
//  RD_LAT      1      BRAM read latency in clocks, 1..3
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high; clears all state
//  start      in   1       pulse; begins a frame when idle
//  busy       out  1       high from accepted start until done
//  done       out  1       one-cycle pulse after the last write of a frame
//  step       out  1       advance pulse to address counter, one per index issued
//  rd_en      out  1       read enable to the 5 input BRAMs, coincident with step
//  d1..d5     in   DATA_W  bank read data, valid RD_LAT clocks after rd_en
//  coef_we    in   1       coefficient write strobe
//  coef_sel   in   3       coefficient index 0..4 (tap k multiplies d(k+1))
//  coef_data  in   COEF_W  coefficient value
//  out_wr_en  out  1       result BRAM write enable
//  out_addr   out  14      result index 0..BANK_DEPTH-1
//  out_data   out  DATA_W  saturated result
// BEHAVIOUR
//  Reset: busy=0, done=0, step=0, rd_en=0, out_wr_en=0, out_addr=0, out_data=0, FSM=IDLE.
//  Reset also zeroes all coefs, the issue index and all pipeline valid bits. Reset mid-frame aborts with no done.
//  FSM states IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE : start=1 -> RUN, busy=1 next cycle, issue index=0.
//   RUN  : each cycle step=1, rd_en=1, index++. After issuing index BANK_DEPTH-1 -> DRAIN (no wrap to 0 issued).
//   DRAIN: step=rd_en=0. Waits until all pipeline valid bits are 0 -> DONE.
//   DONE : done=1 for one cycle, busy=0 next cycle -> IDLE.
//  start while busy is ignored. start in the same cycle as reset is ignored.
//  coef_we is honoured only in IDLE; coef_sel>4 is ignored. Coefs are stable for the whole frame.
//  Pipeline: delay line of RD_LAT valid bits aligns index with returned data.
//   S1 registers 5 products: zero-extended d(k) * signed coef(k), DATA_W+COEF_W+1 bits.
//   S2 registers the sign-extended ACC_W sum of the 5 products.
//   S3 adds round = 2^(SHIFT-1) (0 if SHIFT=0), arithmetic >>> SHIFT, clamps to [0, 2^DATA_W-1].
//   S3 drives out_data/out_addr with out_wr_en=1.
//  Latency: rd_en at cycle t -> out_wr_en at t+RD_LAT+3. Exactly BANK_DEPTH writes per frame.
//  Writes go out in index order with no gaps; the last write has out_addr=BANK_DEPTH-1.
//  done asserts the cycle after the last write. out_data/out_addr hold their last values when out_wr_en=0.
// STRUCTURE
//  conv_pkg: BANK_DEPTH, bank base offsets (0, 11520, 23040, 34560, 46080), FSM state localparams,
//  and the default DATA_W/COEF_W/ACC_W.
//  Sub-module conv_round_sat: combinational round + shift + clamp (ACC_W in, DATA_W out), instanced in S3.
//  FSM, index counter, valid delay line and S1/S2 registers stay in this module.
// TESTING
//  Use BANK_DEPTH=16 and RD_LAT=1 unless stated.
//  1 Identity: coefs {0,0,16,0,0}, SHIFT=4, d3=index*7 -> out_data=d3 at every out_addr; first write 4 clocks after first rd_en.
//  2 Saturation: all d=255, all coefs=127 -> out_data=255. All coefs=-128 -> out_data=0.
//  3 Rounding: coefs {1,0,0,0,0}, d1=8 -> sum 8, (8+8)>>4 = 1. d1=7 -> (7+8)>>4 = 0.
//  4 Frame boundary: exactly 16 writes, out_addr 0..15, 16 step pulses. done is 1 cycle after write 15, then busy=0.
//  5 Protocol: start pulsed mid-frame and coef_we mid-frame -> both ignored, results unchanged.
//    Repeat test 1 with RD_LAT=3 -> latency 6.
//  6 Reset at index 9 -> same cycle+1 all outputs 0, no done. Next start runs a clean 16-write frame, coefs zeroed.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the 5-tap convolution engine.
package conv_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_COEF_W     = 8;
    localparam int DEF_ACC_W      = 20;
    localparam int DEF_BANK_DEPTH = 11520;
    localparam int NUM_TAPS       = 5;
    localparam int ADDR_W         = 14;

    // Word offset of bank k in the input BRAM address space (k * DEF_BANK_DEPTH).
    localparam logic [NUM_TAPS-1:0][16:0] BANK_BASE = {
        17'd46080, 17'd34560, 17'd23040, 17'd11520, 17'd0
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/conv_round_sat.sv
// Round-half-up, arithmetic right shift and clamp of a signed accumulator
// into an unsigned pixel. Purely combinational.
module conv_round_sat #(
    parameter int ACC_W  = 20,
    parameter int DATA_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] pix_o
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam int                  RS   = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND  = (SHIFT > 0) ? ((ACC_W+1)'(1) << RS) : '0;
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << DATA_W) - 1);

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shf;

    assign ext = (ACC_W+1)'($signed(acc_i));
    assign rnd = ext + RND;
    assign shf = rnd >>> SHIFT;

    // Clamp the scaled value into the unsigned pixel range.
    always_comb begin
        if (shf < 0)
            pix_o = '0;
        else if (shf > MAXV)
            pix_o = '1;
        else
            pix_o = shf[DATA_W-1:0];
    end

endmodule

// File: rtl/conv_tap5_engine.sv
// Frame-level 5-tap convolution engine: steps the bank address counter once
// per pixel, multiplies the 5 returned words by the tap coefficients, sums,
// rounds/saturates, and writes one result pixel per index.
module conv_tap5_engine
    import conv_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int COEF_W     = DEF_COEF_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int SHIFT      = 4,
    parameter int BANK_DEPTH = DEF_BANK_DEPTH,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              step,
    output logic              rd_en,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    input  logic [DATA_W-1:0] d4,
    input  logic [DATA_W-1:0] d5,
    input  logic              coef_we,
    input  logic [2:0]        coef_sel,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    // Stage k of vld_q is set k clocks after rd_en; data arrives at RD_LAT,
    // then S1 (products), S2 (sum), S3 (output register).
    localparam int STAGES = RD_LAT + 3;
    localparam int PROD_W = DATA_W + COEF_W + 1;

    state_e                               state_q, state_d;
    logic [ADDR_W-1:0]                    idx_q, idx_d;
    logic [NUM_TAPS-1:0][COEF_W-1:0]      coef_q, coef_d;
    logic [STAGES:1]                      vld_q, vld_d;
    logic [STAGES-1:1][ADDR_W-1:0]        ipipe_q, ipipe_d;
    logic [NUM_TAPS-1:0][PROD_W-1:0]      prod_q, prod_d;
    logic [ACC_W-1:0]                     sum_q, sum_d;
    logic [DATA_W-1:0]                    out_data_q, out_data_d;
    logic [ADDR_W-1:0]                    out_addr_q, out_addr_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0]      d_arr;
    logic [DATA_W-1:0]                    sat_pix;

    assign d_arr = {d5, d4, d3, d2, d1};

    // Next-state logic: one full frame per accepted start, drain, pulse done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (idx_q == ADDR_W'(BANK_DEPTH - 1)) state_d = ST_DRAIN;
            // Leave once nothing older than the output stage is in flight,
            // so done lands the cycle after the final write.
            ST_DRAIN: if (vld_q[STAGES-1:1] == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        step  = (state_q == ST_RUN);
        rd_en = (state_q == ST_RUN);
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
    end

    // Issue index and coefficient bank; coefficients only change while idle.
    always_comb begin
        idx_d  = idx_q;
        coef_d = coef_q;
        if (state_q == ST_IDLE)
            idx_d = '0;
        else if (state_q == ST_RUN)
            idx_d = idx_q + 1'b1;
        if (state_q == ST_IDLE && coef_we) begin
            for (int k = 0; k < NUM_TAPS; k++)
                if (coef_sel == 3'(k)) coef_d[k] = coef_data;
        end
    end

    // Datapath: valid/index delay line, products, sum, registered result.
    always_comb begin
        vld_d = {vld_q[STAGES-1:1], rd_en};
        ipipe_d = ipipe_q;
        ipipe_d[1] = idx_q;
        for (int k = 2; k < STAGES; k++)
            ipipe_d[k] = ipipe_q[k-1];
        // Zero-extended pixel times sign-extended coef; low PROD_W bits
        // of the product are exact for this signed/unsigned mix.
        for (int k = 0; k < NUM_TAPS; k++)
            prod_d[k] = PROD_W'(d_arr[k]) * PROD_W'($signed(coef_q[k]));
        sum_d = '0;
        for (int k = 0; k < NUM_TAPS; k++)
            sum_d = sum_d + ACC_W'($signed(prod_q[k]));
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        if (vld_q[STAGES-1]) begin
            out_data_d = sat_pix;
            out_addr_d = ipipe_q[STAGES-1];
        end
    end

    conv_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT)
    ) u_round_sat (
        .acc_i (sum_q),
        .pix_o (sat_pix)
    );

    // State registers; reset clears everything and aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            coef_q     <= '0;
            vld_q      <= '0;
            ipipe_q    <= '0;
            prod_q     <= '0;
            sum_q      <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            coef_q     <= coef_d;
            vld_q      <= vld_d;
            ipipe_q    <= ipipe_d;
            prod_q     <= prod_d;
            sum_q      <= sum_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign out_wr_en = vld_q[STAGES];
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;

endmodule
